// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the MEM pipeline stage.
// Holds the bus payload layouts, the sel_rf_w_data write-back source
// encoding and the load-buffer FSM state encoding.
package mem_stage_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  // Write-back data source selector
  typedef enum logic [1:0] {
    SEL_WD_ALU  = 2'b00,
    SEL_WD_PC8  = 2'b01,
    SEL_WD_LOAD = 2'b10,
    SEL_WD_ZERO = 2'b11
  } sel_wd_e;

  // Load-data capture states
  typedef enum logic [1:0] {
    LB_EMPTY = 2'd0,
    LB_FRESH = 2'd1,
    LB_HELD  = 2'd2
  } lb_state_e;

  // EXE -> MEM payload, bit 72 down to bit 0
  typedef struct packed {
    sel_wd_e                 sel_rf_w_data;  // [72:71]
    logic                    sel_rf_w_en;    // [70]
    logic                    sel_mem_gene;   // [69]
    logic [DATA_W-1:0]       pc_plus_8;      // [68:37]
    logic [DATA_W-1:0]       alu_res;        // [36:5]
    logic [REG_ADDR_W-1:0]   dest;           // [4:0]
  } exe_to_mem_t;

  // MEM -> WB payload, bit 69 down to bit 0
  typedef struct packed {
    logic                    sel_rf_w_en;    // [69]
    logic [DATA_W-1:0]       pc_plus_8;      // [68:37]
    logic [DATA_W-1:0]       rf_w_data;      // [36:5]
    logic [REG_ADDR_W-1:0]   dest;           // [4:0]
  } mem_to_wb_t;

  // MEM -> stall unit, bit 6 down to bit 0
  typedef struct packed {
    logic                    valid;          // [6]
    logic                    sel_mem_gene;   // [5]
    logic [REG_ADDR_W-1:0]   dest;           // [4:0]
  } mem_to_st_t;

  // MEM -> bypass unit, bit 38 down to bit 0
  typedef struct packed {
    logic                    sel_rf_w_en;    // [38]
    logic                    valid;          // [37]
    logic [REG_ADDR_W-1:0]   dest;           // [36:32]
    logic [DATA_W-1:0]       rf_w_data;      // [31:0]
  } mem_to_by_t;

  localparam int unsigned EXE_TO_MEM_W = $bits(exe_to_mem_t);
  localparam int unsigned MEM_TO_WB_W  = $bits(mem_to_wb_t);
  localparam int unsigned MEM_TO_ST_W  = $bits(mem_to_st_t);
  localparam int unsigned MEM_TO_BY_W  = $bits(mem_to_by_t);

endpackage

// File: rtl/mem_load_buffer.sv
// mem_load_buffer: keeps the data-RAM read word stable for the whole time
// an instruction resides in MEM. The synchronous RAM presents the word only
// in the first cycle after the accepting edge (FRESH); if WB stalls at that
// point the word is copied into a hold register (HELD) and served from there.
// Ports:
//   clk, reset      clock, async active-high reset
//   i_accept        stage accepts at the next edge (MEM_allow_in)
//   i_in_valid      upstream instruction valid (EXE_to_MEM_valid)
//   i_ram_data      synchronous data-RAM read word
//   o_load_word_c   load word for the resident instruction (combinational)
module mem_load_buffer
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_accept,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_ram_data,
  output logic [DATA_W-1:0] o_load_word_c
);

  lb_state_e         r_state;
  lb_state_e         w_state_nxt;
  logic [DATA_W-1:0] r_hold;
  logic              w_hold_en;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= LB_EMPTY;
    else       r_state <= w_state_nxt;
  end

  // Hold register, written only on the FRESH -> HELD transition
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_hold <= '0;
    else if (w_hold_en) r_hold <= i_ram_data;
  end

  // Next state, hold enable and load-word select
  always_comb begin
    w_state_nxt   = r_state;
    w_hold_en     = 1'b0;
    o_load_word_c = r_hold;

    if (i_accept) begin
      // Accept wins from any state, covering back-to-back accept+drain
      w_state_nxt = i_in_valid ? LB_FRESH : LB_EMPTY;
    end else begin
      case (r_state)
        // Not accepting while FRESH means WB is stalling the resident op
        LB_FRESH: begin
          w_state_nxt = LB_HELD;
          w_hold_en   = 1'b1;
        end
        default: ;
      endcase
    end

    case (r_state)
      LB_FRESH: o_load_word_c = i_ram_data;
      default:  o_load_word_c = r_hold;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage. Registers the EXE->MEM bus with a valid bit
// under a valid/allow-in handshake, selects the register-file write data and
// drives the WB, stall-unit and bypass-unit buses from registered state.
// Ports:
//   clk, reset          clock, async active-high reset
//   EXE_to_MEM_bus      incoming instruction payload
//   EXE_to_MEM_valid    upstream holds a valid instruction
//   MEM_allow_in        stage accepts at the next edge
//   data_ram_r_data     synchronous data-RAM read word
//   WB_allow_in         downstream accepts at the next edge
//   MEM_to_WB_valid     valid instruction presented to WB
//   MEM_to_WB_bus       payload to WB
//   MEM_to_ST_bus       {valid, sel_MEM_gene, dest} to the stall unit
//   MEM_to_BY_bus       {rf_w_en, valid, dest, w_data} to the bypass unit
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned EXE_TO_MEM_BUS_WD = 73,
  parameter int unsigned MEM_TO_WB_BUS_WD  = 70
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [EXE_TO_MEM_BUS_WD-1:0] EXE_to_MEM_bus,
  input  logic                         EXE_to_MEM_valid,
  output logic                         MEM_allow_in,
  input  logic [DATA_W-1:0]            data_ram_r_data,
  input  logic                         WB_allow_in,
  output logic                         MEM_to_WB_valid,
  output logic [MEM_TO_WB_BUS_WD-1:0]  MEM_to_WB_bus,
  output logic [MEM_TO_ST_W-1:0]       MEM_to_ST_bus,
  output logic [MEM_TO_BY_W-1:0]       MEM_to_BY_bus
);

  logic              r_valid;
  exe_to_mem_t       r_bus;
  exe_to_mem_t       w_exe_bus;
  logic              w_ready_go;
  logic              w_allow_in;
  logic [DATA_W-1:0] w_load_word;
  logic [DATA_W-1:0] w_rf_w_data;
  mem_to_wb_t        w_wb_bus;
  mem_to_st_t        w_st_bus;
  mem_to_by_t        w_by_bus;

  assign w_exe_bus  = exe_to_mem_t'(EXE_to_MEM_bus);
  assign w_ready_go = 1'b1;
  assign w_allow_in = ~r_valid | (w_ready_go & WB_allow_in);

  // Stage valid bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           r_valid <= 1'b0;
    else if (w_allow_in) r_valid <= EXE_to_MEM_valid;
  end

  // Payload register; bubbles leave the previous contents in place
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             r_bus <= '0;
    else if (w_allow_in & EXE_to_MEM_valid) r_bus <= w_exe_bus;
  end

  // Load-data capture
  mem_load_buffer u_load_buffer (
    .clk           (clk),
    .reset         (reset),
    .i_accept      (w_allow_in),
    .i_in_valid    (EXE_to_MEM_valid),
    .i_ram_data    (data_ram_r_data),
    .o_load_word_c (w_load_word)
  );

  // Register-file write data select
  always_comb begin
    w_rf_w_data = '0;
    case (r_bus.sel_rf_w_data)
      SEL_WD_ALU:  w_rf_w_data = r_bus.alu_res;
      SEL_WD_PC8:  w_rf_w_data = r_bus.pc_plus_8;
      SEL_WD_LOAD: w_rf_w_data = w_load_word;
      SEL_WD_ZERO: w_rf_w_data = '0;
      default:     w_rf_w_data = '0;
    endcase
  end

  // Output bus assembly
  always_comb begin
    w_wb_bus.sel_rf_w_en  = r_bus.sel_rf_w_en;
    w_wb_bus.pc_plus_8    = r_bus.pc_plus_8;
    w_wb_bus.rf_w_data    = w_rf_w_data;
    w_wb_bus.dest         = r_bus.dest;

    w_st_bus.valid        = r_valid;
    w_st_bus.sel_mem_gene = r_bus.sel_mem_gene;
    w_st_bus.dest         = r_bus.dest;

    w_by_bus.sel_rf_w_en  = r_bus.sel_rf_w_en;
    w_by_bus.valid        = r_valid;
    w_by_bus.dest         = r_bus.dest;
    w_by_bus.rf_w_data    = w_rf_w_data;
  end

  assign MEM_allow_in    = w_allow_in;
  assign MEM_to_WB_valid = r_valid & w_ready_go;
  assign MEM_to_WB_bus   = MEM_TO_WB_BUS_WD'(w_wb_bus);
  assign MEM_to_ST_bus   = w_st_bus;
  assign MEM_to_BY_bus   = w_by_bus;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scenarios followed by random traffic, all checked
// against a residency-level model of the MEM stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [72:0] exe_bus;
  logic        exe_valid;
  logic        mem_allow_in;
  logic [31:0] ram_data;
  logic        wb_allow;
  logic        wb_valid;
  logic [69:0] wb_bus;
  logic [6:0]  st_bus;
  logic [38:0] by_bus;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: what instruction sits in MEM, whether this is its first cycle,
  // and the load word recorded when it stayed past its first cycle.
  logic        m_valid;
  logic [72:0] m_bus;
  logic        m_first;
  logic [31:0] m_load;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk              (clk),
    .reset            (reset),
    .EXE_to_MEM_bus   (exe_bus),
    .EXE_to_MEM_valid (exe_valid),
    .MEM_allow_in     (mem_allow_in),
    .data_ram_r_data  (ram_data),
    .WB_allow_in      (wb_allow),
    .MEM_to_WB_valid  (wb_valid),
    .MEM_to_WB_bus    (wb_bus),
    .MEM_to_ST_bus    (st_bus),
    .MEM_to_BY_bus    (by_bus)
  );

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [72:0] mk(input logic [1:0] sel, input logic en, input logic gene,
                                     input logic [31:0] pc8, input logic [31:0] alu,
                                     input logic [4:0] dest);
    return {sel, en, gene, pc8, alu, dest};
  endfunction

  function automatic logic [31:0] exp_word();
    case (m_bus[72:71])
      2'b00:   return m_bus[36:5];
      2'b01:   return m_bus[68:37];
      2'b10:   return m_first ? ram_data : m_load;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_bus   = '0;
    m_first = 1'b0;
    m_load  = '0;
  endtask

  task automatic model_check();
    logic [31:0] w;
    logic        known;
    w     = exp_word();
    known = m_valid || (m_bus[72:71] != 2'b10);
    chk("wb_valid", 70'(wb_valid), 70'(m_valid));
    chk("allow_in", 70'(mem_allow_in), 70'(!m_valid || wb_allow));
    chk("st_bus", 70'(st_bus), 70'({m_valid, m_bus[69], m_bus[4:0]}));
    if (known) begin
      chk("wb_bus", 70'(wb_bus), 70'({m_bus[70], m_bus[68:37], w, m_bus[4:0]}));
      chk("by_bus", 70'(by_bus), 70'({m_bus[70], m_valid, m_bus[4:0], w}));
    end else begin
      chk("wb_bus_ctl", 70'({wb_bus[69:37], wb_bus[4:0]}), 70'({m_bus[70], m_bus[68:37], m_bus[4:0]}));
      chk("by_bus_ctl", 70'(by_bus[38:32]), 70'({m_bus[70], m_valid, m_bus[4:0]}));
    end
  endtask

  // Advance the model across one rising edge using the current inputs
  task automatic model_edge();
    logic allow;
    allow = !m_valid || wb_allow;
    if (m_first && !allow) m_load = ram_data;
    if (allow) begin
      m_valid = exe_valid;
      if (exe_valid) m_bus = exe_bus;
      m_first = exe_valid;
    end else begin
      m_first = 1'b0;
    end
  endtask

  task automatic tick();
    #1;
    model_check();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [95:0] rnd;
    reset     = 1'b1;
    exe_valid = 1'b0;
    exe_bus   = '0;
    wb_allow  = 1'b1;
    ram_data  = '0;
    model_reset();

    // During reset
    #2;
    model_check();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    // Single load, WB ready
    exe_bus = mk(2'b10, 1'b1, 1'b1, 32'h1000, 32'h2000, 5'd5); exe_valid = 1'b1; ram_data = $urandom;
    tick();
    exe_valid = 1'b0; ram_data = 32'hDEADBEEF;
    #1;
    chk("ld_data", 70'(wb_bus[36:5]), 70'(32'hDEADBEEF));
    chk("ld_dest", 70'(wb_bus[4:0]), 70'(5'd5));
    chk("ld_valid", 70'(wb_valid), 70'(1'b1));
    tick();
    #1;
    chk("ld_one_cycle", 70'(wb_valid), 70'(1'b0));
    tick();

    // Load under a three-cycle WB stall
    exe_bus = mk(2'b10, 1'b1, 1'b1, 32'h1004, 32'h2004, 5'd9); exe_valid = 1'b1; wb_allow = 1'b1;
    tick();
    exe_bus = mk(2'b00, 1'b1, 1'b0, 32'h1008, 32'h77, 5'd3); exe_valid = 1'b1;
    wb_allow = 1'b0; ram_data = 32'hDEADBEEF;
    #1;
    chk("stall_data0", 70'(wb_bus[36:5]), 70'(32'hDEADBEEF));
    chk("stall_allow0", 70'(mem_allow_in), 70'(1'b0));
    tick();
    for (int i = 0; i < 2; i++) begin
      ram_data = 32'h12345678;
      #1;
      chk("stall_data", 70'(wb_bus[36:5]), 70'(32'hDEADBEEF));
      chk("stall_allow", 70'(mem_allow_in), 70'(1'b0));
      tick();
    end
    wb_allow = 1'b1; ram_data = 32'h12345678;
    #1;
    chk("release_data", 70'(wb_bus[36:5]), 70'(32'hDEADBEEF));
    chk("release_allow", 70'(mem_allow_in), 70'(1'b1));
    tick();
    exe_valid = 1'b0;
    tick();

    // ALU then link, back-to-back
    exe_bus = mk(2'b00, 1'b1, 1'b0, 32'h0, 32'h10, 5'd2); exe_valid = 1'b1;
    tick();
    exe_bus = mk(2'b01, 1'b1, 1'b0, 32'hBFC00008, 32'hFFFF, 5'd31);
    #1;
    chk("alu_data", 70'(wb_bus[36:5]), 70'(32'h10));
    chk("alu_valid", 70'(wb_valid), 70'(1'b1));
    tick();
    exe_valid = 1'b0;
    #1;
    chk("link_data", 70'(wb_bus[36:5]), 70'(32'hBFC00008));
    chk("link_valid", 70'(wb_valid), 70'(1'b1));
    tick();

    // Stall/bypass bus contents for a load to r7
    exe_bus = mk(2'b10, 1'b1, 1'b1, 32'h2000, 32'h3000, 5'd7); exe_valid = 1'b1;
    tick();
    exe_valid = 1'b0; ram_data = $urandom;
    #1;
    chk("st_bus_ld7", 70'(st_bus), 70'(7'b1100111));
    chk("by_hdr_ld7", 70'(by_bus[38:32]), 70'({1'b1, 1'b1, 5'd7}));
    tick();

    // Bubble accepted on the previous edge
    #1;
    chk("bubble_wb_valid", 70'(wb_valid), 70'(1'b0));
    chk("bubble_by_valid", 70'(by_bus[37]), 70'(1'b0));
    chk("bubble_st_valid", 70'(st_bus[6]), 70'(1'b0));
    tick();

    // Async reset in the middle of a held stall
    exe_bus = mk(2'b10, 1'b1, 1'b1, 32'h4000, 32'h5000, 5'd12); exe_valid = 1'b1; wb_allow = 1'b1;
    tick();
    exe_valid = 1'b0; wb_allow = 1'b0; ram_data = 32'hCAFEF00D;
    tick();
    ram_data = $urandom;
    tick();
    #1;
    chk("held_data", 70'(wb_bus[36:5]), 70'(32'hCAFEF00D));
    #1;
    reset = 1'b1;
    #1;
    chk("rst_wb_valid", 70'(wb_valid), 70'(1'b0));
    chk("rst_allow", 70'(mem_allow_in), 70'(1'b1));
    chk("rst_st_bus", 70'(st_bus), 70'(7'b0));
    chk("rst_by_valid", 70'(by_bus[37]), 70'(1'b0));
    model_reset();
    @(posedge clk); #1;
    model_check();
    reset = 1'b0;
    wb_allow = 1'b1;
    tick();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rnd       = {$urandom, $urandom, $urandom};
      exe_bus   = rnd[72:0];
      exe_valid = ($urandom_range(0, 3) != 0);
      wb_allow  = ($urandom_range(0, 2) != 0);
      ram_data  = $urandom;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter EXE_TO_MEM_BUS_WD, default 73, width of the incoming EXE-to-MEM bus.
REQ-002 Parameter MEM_TO_WB_BUS_WD, default 70, width of the outgoing MEM-to-WB bus.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 EXE_to_MEM_bus  in  73  {sel_rf_w_data[72:71], sel_rf_w_en[70], sel_MEM_gene[69], PC_plus_8[68:37], alu_res[36:5], RegFile_target_w_addr[4:0]}.
REQ-006 EXE_to_MEM_valid  in  1  upstream holds a valid instruction this cycle.
REQ-007 MEM_allow_in  out  1  stage accepts a new instruction at the next edge.
REQ-008 data_ram_r_data  in  32  synchronous data-RAM read word, valid only in the first cycle after the accepting edge.
REQ-009 WB_allow_in  in  1  downstream accepts at the next edge.
REQ-010 MEM_to_WB_valid  out  1  stage presents a valid instruction to WB.
REQ-011 MEM_to_WB_bus  out  70  {sel_rf_w_en[69], PC_plus_8[68:37], RegFile_w_data[36:5], RegFile_target_w_addr[4:0]}.
REQ-012 MEM_to_ST_bus  out  7  {MEM_valid[6], sel_MEM_gene[5], RegFile_target_w_addr[4:0]}, feeds the stall unit.
REQ-013 MEM_to_BY_bus  out  39  {sel_rf_w_en[38], MEM_valid[37], RegFile_target_w_addr[36:32], RegFile_w_data[31:0]}, feeds the bypass unit.

Function
REQ-014 MEM_ready_go SHALL be constant 1.
REQ-015 MEM_to_WB_valid SHALL equal MEM_valid & MEM_ready_go.
REQ-016 MEM_allow_in SHALL equal ~MEM_valid | (MEM_ready_go & WB_allow_in).
REQ-017 When MEM_allow_in is high, MEM_valid SHALL load EXE_to_MEM_valid at the edge; otherwise MEM_valid SHALL hold.
REQ-018 The bus register SHALL load EXE_to_MEM_bus only when MEM_allow_in & EXE_to_MEM_valid; otherwise it SHALL hold.
REQ-019 RegFile_w_data SHALL be selected by sel_rf_w_data: 00 alu_res, 01 PC_plus_8, 10 load word, 11 32'h0.
REQ-020 The load-data FSM SHALL have states EMPTY, FRESH and HELD.
REQ-021 The FSM SHALL move to FRESH from any state on an accepting edge with EXE_to_MEM_valid=1.
REQ-022 The FSM SHALL move to EMPTY on an accepting edge with EXE_to_MEM_valid=0.
REQ-023 FRESH SHALL move to HELD when WB_allow_in=0, latching data_ram_r_data into a 32-bit hold register at that edge.
REQ-024 HELD SHALL remain HELD, with the hold register frozen, until the next accepting edge.
REQ-025 The load word SHALL be data_ram_r_data in FRESH and the hold register in HELD; in EMPTY it is don't-care.
REQ-026 Load data SHALL stay stable for the whole residency of an instruction, however long WB stalls.
REQ-027 Simultaneous accept and drain SHALL be handled as back-to-back flow: the new instruction enters FRESH with no bubble.
REQ-028 All outputs SHALL be combinational from the registered state, and the stage SHALL add exactly one cycle of latency.
REQ-029 MEM_to_BY_bus and MEM_to_ST_bus SHALL carry the current register contents even when MEM_valid=0; consumers qualify them with the valid bit.

Reset
REQ-030 An asserted reset SHALL immediately clear MEM_valid to 0, set the FSM to EMPTY, and zero the bus and hold registers.
REQ-031 During and after reset, MEM_to_WB_valid SHALL be 0, MEM_allow_in SHALL be 1, and the valid bits in the ST and BY buses SHALL be 0.
REQ-032 Reset asserted mid-stall SHALL discard the in-flight instruction and its held data.

Structure
REQ-033 Bus widths, bus bit positions, sel_rf_w_data encodings and FSM state encodings SHALL live in the shared myCPU header/package.
REQ-034 The load-data capture (FSM plus hold register) SHALL be one sub-module, mem_load_buffer; everything else is flat.

Verification
REQ-035 Single load: bus sel_rf_w_data=10, dest=5, RAM word 0xDEADBEEF the next cycle, WB_allow_in=1 -> MEM_to_WB_bus data 0xDEADBEEF, dest 5, valid for exactly one cycle.
REQ-036 Load under stall: same load with WB_allow_in=0 for 3 cycles while RAM output changes to 0x12345678 -> data stays 0xDEADBEEF all 4 cycles, and MEM_allow_in=0 until the release.
REQ-037 ALU and link: sel_rf_w_data=00 with alu_res=0x10, then 01 with PC_plus_8=0xBFC00008 -> WB data 0x10 then 0xBFC00008, back-to-back with no bubble.
REQ-038 Bypass/stall buses: a valid load to dest=7 -> MEM_to_ST_bus=7'b1_1_00111 and MEM_to_BY_bus[38:32]={1,1,7}.
REQ-039 Async reset: assert reset mid-cycle during a HELD stall -> MEM_to_WB_valid drops before the next edge, and MEM_allow_in=1 after reset.
REQ-040 Bubble: EXE_to_MEM_valid=0 on an accepting edge -> MEM_to_WB_valid=0, FSM EMPTY, and the BY valid bit 0.
